input_keypad_scan: RTL and testbench

- 4x4 matrix-keypad scanner; the input-side counterpart of the 8-digit seven-segment display driver.
- Drives rows one-hot active-low and samples active-low columns.
- Debounces presses and releases, then emits a 5-bit symbol code in the display's code space (0-15 = hex digit, 31 = blank) with a one-cycle valid strobe.
- Sits between board keypad pins and the core control logic, optionally also feeding the display's 40-bit show bus.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_tick_gen.sv | 29 ++
 rtl/input_keypad_scan.sv | 150 +++++++++++++++
 tb/tb_input_keypad_scan.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the seven-segment display driver.
// Holds the scan FSM state type, the display symbol code space and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_PRESS,
        HELD
    } scan_state_t;

    localparam logic [4:0] BLANK_CODE = 5'd31;
    localparam logic [3:0] ROW_RESET  = 4'b1110;
    localparam logic [3:0] COL_IDLE   = 4'b1111;

    // Display symbol codes: 0-15 render as hex digits, 31 renders as a blank digit.
    localparam logic [4:0] SYM_0     = 5'd0;
    localparam logic [4:0] SYM_1     = 5'd1;
    localparam logic [4:0] SYM_2     = 5'd2;
    localparam logic [4:0] SYM_3     = 5'd3;
    localparam logic [4:0] SYM_4     = 5'd4;
    localparam logic [4:0] SYM_5     = 5'd5;
    localparam logic [4:0] SYM_6     = 5'd6;
    localparam logic [4:0] SYM_7     = 5'd7;
    localparam logic [4:0] SYM_8     = 5'd8;
    localparam logic [4:0] SYM_9     = 5'd9;
    localparam logic [4:0] SYM_A     = 5'd10;
    localparam logic [4:0] SYM_B     = 5'd11;
    localparam logic [4:0] SYM_C     = 5'd12;
    localparam logic [4:0] SYM_D     = 5'd13;
    localparam logic [4:0] SYM_E     = 5'd14;
    localparam logic [4:0] SYM_F     = 5'd15;
    localparam logic [4:0] SYM_BLANK = BLANK_CODE;

    localparam logic [39:0] HISTORY_BLANK = {8{BLANK_CODE}};

    function automatic logic single_low(input logic [3:0] cols);
        return $countones(~cols) == 1;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] make_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return {1'b0, row_idx, col_idx};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running enable-tick generator: one-clk pulse every SCAN_PERIOD clocks.
// Replaces derived slow clocks so everything stays in the clk domain.
module keypad_tick_gen #(
    parameter int SCAN_PERIOD = 250000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_PERIOD - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/input_keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce, emitting display-space key codes.
// Define KEYPAD_HISTORY_EN to build the 8-entry code history shift register.
module input_keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_PERIOD    = 250000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [4:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [39:0] history
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_DONE = DW'(DEBOUNCE_TICKS);

    logic        tick;
    logic [3:0]  cs_meta, cs;

    scan_state_t state, state_nxt;
    logic [1:0]    row_idx, row_idx_nxt;
    logic [1:0]    col_idx, col_idx_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt, deb_inc;
    logic [4:0]    code_nxt;
    logic          valid_nxt, down_nxt;

    keypad_tick_gen #(.SCAN_PERIOD(SCAN_PERIOD)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Columns are asynchronous to clk; only the second flop's output is ever decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= COL_IDLE;
            cs      <= COL_IDLE;
        end else begin
            cs_meta <= col;
            cs      <= cs_meta;
        end
    end

    assign deb_inc = deb_cnt + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        col_idx_nxt = col_idx;
        deb_nxt     = deb_cnt;
        code_nxt    = key_code;
        valid_nxt   = 1'b0;
        down_nxt    = key_down;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (single_low(cs)) begin
                        col_idx_nxt = low_index(cs);
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE_PRESS;
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (cs == ~(4'b0001 << col_idx)) begin
                        if (deb_inc == DEB_DONE) begin
                            code_nxt  = make_code(row_idx, col_idx);
                            valid_nxt = 1'b1;
                            down_nxt  = 1'b1;
                            deb_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                        deb_nxt     = '0;
                        state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    // Release needs an unbroken run of idle ticks; any low column restarts it.
                    if (cs == COL_IDLE) begin
                        if (deb_inc == DEB_DONE) begin
                            down_nxt    = 1'b0;
                            row_idx_nxt = row_idx + 1'b1;
                            deb_nxt     = '0;
                            state_nxt   = SCAN;
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        deb_nxt = '0;
                    end
                end
                default: begin
                    deb_nxt   = '0;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            key_code  <= BLANK_CODE;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            col_idx   <= col_idx_nxt;
            deb_cnt   <= deb_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_down  <= down_nxt;
        end
    end

    assign row = ~(4'b0001 << row_idx);

`ifdef KEYPAD_HISTORY_EN
    logic [39:0] history_q;

    // NOTE: the history is reset to eight blanks so the display shows nothing before the first key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history_q <= HISTORY_BLANK;
        end else if (valid_nxt) begin
            history_q <= {history_q[34:0], code_nxt};
        end
    end

    assign history = history_q;
`else
    assign history = HISTORY_BLANK;
`endif

endmodule

// File: tb/tb_input_keypad_scan.sv
// Self-checking bench for input_keypad_scan: a physical keypad model drives the columns and a
// tick-level reference model of the scan/debounce rules predicts every observable output.
module tb_input_keypad_scan;
    import keypad_pkg::*;

    localparam int P = 4;
    localparam int D = 3;
    localparam int IDLE    = 0;
    localparam int CONFIRM = 1;
    localparam int HOLD    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col = 4'hF;
    logic [3:0]  row;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [39:0] history;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    input_keypad_scan #(.SCAN_PERIOD(P), .DEBOUNCE_TICKS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .history   (history)
    );

    logic [3:0] row_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reference model state, in terms of the keypad's behaviour rather than the RTL's registers.
    int         m_row, m_mode, m_cand_col, m_stable;
    logic [4:0] m_code;
    logic       m_down, m_pulse;
    logic [4:0] m_hist [$];

    int          obs_pulses;
    logic [51:0] obs_v, exp_v;

    // Pressed key set: bit r*4+c is the key at row r, column c.
    function automatic logic [3:0] phys_col(input logic [3:0] rows, input logic [15:0] p);
        logic [3:0] c = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int k = 0; k < 4; k++)
                    if (p[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic logic [39:0] exp_hist();
`ifdef KEYPAD_HISTORY_EN
        logic [39:0] h = '1;
        foreach (m_hist[i]) h = {h[34:0], m_hist[i]};
        return h;
`else
        return 40'hFF_FFFF_FFFF;
`endif
    endfunction

    task automatic model_reset();
        m_row = 0; m_mode = IDLE; m_cand_col = 0; m_stable = 0;
        m_code = 5'd31; m_down = 1'b0; m_pulse = 1'b0;
        m_hist.delete();
        repeat (8) m_hist.push_back(5'd31);
    endtask

    task automatic model_tick(input logic [15:0] p);
        logic [3:0] low;
        int nlow;
        low = p[m_row*4 +: 4];
        nlow = $countones(low);
        m_pulse = 1'b0;
        case (m_mode)
            IDLE: begin
                if (nlow == 1) begin
                    for (int c = 0; c < 4; c++) if (low[c]) m_cand_col = c;
                    m_mode = CONFIRM;
                    m_stable = 0;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            CONFIRM: begin
                if (nlow == 1 && low[m_cand_col]) begin
                    m_stable++;
                    if (m_stable == D) begin
                        m_code = 5'(m_row*4 + m_cand_col);
                        m_pulse = 1'b1;
                        m_down = 1'b1;
                        m_mode = HOLD;
                        m_stable = 0;
                        m_hist.push_back(m_code);
                        void'(m_hist.pop_front());
                    end
                end else begin
                    m_mode = IDLE;
                    m_row = (m_row + 1) % 4;
                    m_stable = 0;
                end
            end
            default: begin
                if (nlow == 0) begin
                    m_stable++;
                    if (m_stable == D) begin
                        m_down = 1'b0;
                        m_mode = IDLE;
                        m_row = (m_row + 1) % 4;
                        m_stable = 0;
                    end
                end else begin
                    m_stable = 0;
                end
            end
        endcase
    endtask

    // One scan window: P clocks ending on a tick edge, with the key set held constant.
    task automatic run_tick(input logic [15:0] p);
        col = phys_col(row, p);
        obs_pulses = 0;
        repeat (P) begin
            @(posedge clk);
            #1;
            if (key_valid) obs_pulses++;
            col = phys_col(row, p);
        end
        model_tick(p);
        obs_v = {2'(obs_pulses), row, key_code, key_down, history};
        exp_v = {1'b0, m_pulse, row_pat[m_row], m_code, m_down, exp_hist()};
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        col = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        vectors += 5;
        if (row !== 4'b1110) begin miscompares++; $display("FAIL reset_row: got %b expected 1110", row); end
        if (key_code !== 5'd31) begin miscompares++; $display("FAIL reset_code: got %0d expected 31", key_code); end
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL reset_down: got %b expected 0", key_down); end
        if (history !== 40'hFF_FFFF_FFFF) begin miscompares++; $display("FAIL reset_history: got %h expected ffffffffff", history); end
        release_reset();
        for (int t = 0; t < 5; t++) begin
            run_tick(16'h0000);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL idle_scan tick %0d: got %h expected %h", t, obs_v, exp_v); end
            vectors++;
            if (row !== row_pat[(t + 1) % 4]) begin miscompares++; $display("FAIL idle_row tick %0d: got %b expected %b", t, row, row_pat[(t + 1) % 4]); end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int rel_ticks = 0;
        int t = 0;
        while (!m_down && t < 16) begin
            run_tick(16'h0200);
            pulses += obs_pulses;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL press tick %0d: got %h expected %h", t, obs_v, exp_v); end
            t++;
        end
        vectors++;
        if (key_code !== 5'd9 || key_down !== 1'b1) begin
            miscompares++; $display("FAIL press_code: got code %0d down %b expected code 9 down 1", key_code, key_down);
        end
        repeat (5) begin
            run_tick(16'h0200);
            pulses += obs_pulses;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL press_hold: got %h expected %h", obs_v, exp_v); end
        end
        while (m_down && rel_ticks < 10) begin
            run_tick(16'h0000);
            pulses += obs_pulses;
            rel_ticks++;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL release tick %0d: got %h expected %h", rel_ticks, obs_v, exp_v); end
        end
        vectors += 2;
        if (rel_ticks !== D) begin miscompares++; $display("FAIL release_latency: got %0d ticks expected %0d", rel_ticks, D); end
        if (pulses !== 1) begin miscompares++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int t = 0;
        for (int i = 0; i < 4; i++) begin
            run_tick((i % 2 == 0) ? 16'h0001 : 16'h0000);
            pulses += obs_pulses;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL bounce tick %0d: got %h expected %h", i, obs_v, exp_v); end
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL bounce_quiet: got %0d pulses expected 0", pulses); end
        while (!m_down && t < 16) begin
            run_tick(16'h0001);
            pulses += obs_pulses;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL bounce_settle tick %0d: got %h expected %h", t, obs_v, exp_v); end
            t++;
        end
        vectors++;
        if (pulses !== 1 || key_code !== 5'd0) begin
            miscompares++; $display("FAIL bounce_accept: got %0d pulses code %0d expected 1 pulse code 0", pulses, key_code);
        end
        t = 0;
        while (m_down && t < 10) begin
            run_tick(16'h0000);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL bounce_release: got %h expected %h", obs_v, exp_v); end
            t++;
        end
    endtask

    task automatic test_multi_key();
        logic [4:0] code_before;
        int pulses = 0;
        code_before = m_code;
        for (int t = 0; t < 8; t++) begin
            run_tick(16'h0090);
            pulses += obs_pulses;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL multi tick %0d: got %h expected %h", t, obs_v, exp_v); end
        end
        vectors++;
        if (pulses !== 0 || key_code !== code_before) begin
            miscompares++; $display("FAIL multi_ignore: got %0d pulses code %0d expected 0 pulses code %0d", pulses, key_code, code_before);
        end
        run_tick(16'h0000);
    endtask

    task automatic test_reset_mid();
        int t = 0;
        while (!m_down && t < 16) begin
            run_tick(16'h8000);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_press tick %0d: got %h expected %h", t, obs_v, exp_v); end
            t++;
        end
        run_tick(16'h8000);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({row, key_code, key_down, key_valid} !== {4'b1110, 5'd31, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got row %b code %0d down %b valid %b expected 1110 31 0 0", row, key_code, key_down, key_valid);
        end
        col = phys_col(row, 16'h8000);
        repeat (3) @(posedge clk);
        release_reset();
        t = 0;
        while (!m_down && t < 16) begin
            run_tick(16'h8000);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_reaccept tick %0d: got %h expected %h", t, obs_v, exp_v); end
            t++;
        end
        vectors++;
        if (key_code !== 5'd15 || key_down !== 1'b1) begin
            miscompares++; $display("FAIL mid_code: got code %0d down %b expected code 15 down 1", key_code, key_down);
        end
        t = 0;
        while (m_down && t < 10) begin
            run_tick(16'h0000);
            t++;
        end
    endtask

    task automatic test_history();
        logic [39:0] want;
        int keys [3] = '{1, 2, 10};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        foreach (keys[k]) begin
            int t = 0;
            while (!m_down && t < 16) begin
                run_tick(16'(1 << keys[k]));
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL hist_press key %0d: got %h expected %h", keys[k], obs_v, exp_v); end
                t++;
            end
            t = 0;
            while (m_down && t < 10) begin
                run_tick(16'h0000);
                t++;
            end
        end
`ifdef KEYPAD_HISTORY_EN
        want = {25'h1FFFFFF, 5'd1, 5'd2, 5'd10};
`else
        want = 40'hFF_FFFF_FFFF;
`endif
        vectors++;
        if (history !== want) begin miscompares++; $display("FAIL history: got %h expected %h", history, want); end
    endtask

    task automatic test_random();
        logic [15:0] p;
        for (int e = 0; e < 40; e++) begin
            p = 16'(1 << $urandom_range(15));
            if ($urandom_range(4) == 0) p = p | 16'(1 << $urandom_range(15));
            repeat ($urandom_range(10, 1)) begin
                run_tick(($urandom_range(7) == 0) ? 16'h0000 : p);
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL random ep %0d press: got %h expected %h", e, obs_v, exp_v); end
            end
            repeat ($urandom_range(6)) begin
                run_tick(16'h0000);
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL random ep %0d release: got %h expected %h", e, obs_v, exp_v); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_reset_mid();
        test_history();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
